// File: rtl/chan_cksum_fifo.sv
// chan_cksum_fifo
//
// Channel-side endpoint on the comm_fpga_fx2 chanAddr/h2f/f2h interface. Host writes on the data
// channel are buffered in a byte FIFO and summed into a 16-bit running checksum. The host can read
// the bytes back (first-word fall-through), read FIFO status, read the checksum as MSB then LSB
// through a shadow register, and clear the checksum or flush the FIFO via the control channel.
//
// Owned channels (offsets from BASE_CHAN, modulo 128):
//   +0 data     write: push byte (ready = ~full)      read: head byte (valid = ~empty), pops
//   +1 ctrl     write: bit0 clears checksum, bit1 flushes FIFO
//               read:  {full, empty, count zero-extended to 6 bits}
//   +2 cksum hi read:  checksum[15:8]; a consumed read latches checksum[7:0] into the shadow
//   +3 cksum lo read:  shadow
//
// Ports:
//   fx2Clk_in     in   1             system clock, rising edge
//   reset_in      in   1             synchronous, active-high reset
//   chanAddr_in   in   7             selected channel
//   h2fData_in    in   8             host->FPGA byte
//   h2fValid_in   in   1             host->FPGA byte valid
//   h2fReady_out  out  1             block accepts h2fData_in this cycle
//   f2hData_out   out  8             FPGA->host byte
//   f2hValid_out  out  1             f2hData_out valid
//   f2hReady_in   in   1             host consumes f2hData_out this cycle
//   selected_out  out  1             chanAddr_in is one of the four owned channels
//   checksum_out  out  16            running checksum
//   count_out     out  DEPTH_LOG2+1  FIFO occupancy, 0..2**DEPTH_LOG2

`timescale 1ns / 1ps

module chan_cksum_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,     // legal range 2..5
  parameter logic [6:0]  BASE_CHAN  = 7'd0
) (
  input  logic                  fx2Clk_in,
  input  logic                  reset_in,
  input  logic [6:0]            chanAddr_in,
  input  logic [7:0]            h2fData_in,
  input  logic                  h2fValid_in,
  output logic                  h2fReady_out,
  output logic [7:0]            f2hData_out,
  output logic                  f2hValid_out,
  input  logic                  f2hReady_in,
  output logic                  selected_out,
  output logic [15:0]           checksum_out,
  output logic [DEPTH_LOG2:0]   count_out
);

  localparam int unsigned          Depth    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  DepthCnt = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]  CntOne   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne  = (DEPTH_LOG2)'(1);

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,  count_d;
  logic [15:0]           cksum_q,  cksum_d;
  logic [7:0]            shadow_q, shadow_d;

  // ---------------------------------------------------------------------------------------------
  // Channel decode
  // ---------------------------------------------------------------------------------------------
  // Offset arithmetic wraps modulo 128, so a BASE_CHAN near the top of the address space still
  // owns four consecutive channels.
  logic [6:0] chan_off;
  logic       owned;
  logic       sel_data, sel_ctrl, sel_msb;

  assign chan_off = chanAddr_in - BASE_CHAN;
  assign owned    = (chan_off[6:2] == 5'd0);
  assign sel_data = owned && (chan_off[1:0] == 2'd0);
  assign sel_ctrl = owned && (chan_off[1:0] == 2'd1);
  assign sel_msb  = owned && (chan_off[1:0] == 2'd2);

  // ---------------------------------------------------------------------------------------------
  // FIFO status and handshake events (all from pre-edge state)
  // ---------------------------------------------------------------------------------------------
  logic       full, empty;
  logic       push, pop;
  logic       ctrl_wr, do_clear, do_flush;
  logic       latch_lsb;
  logic [7:0] status_byte;
  logic [7:0] head_byte;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  // A full FIFO refuses a push even when a pop happens on the same edge: ready is a function of
  // pre-edge occupancy only.
  assign push      = sel_data && h2fValid_in && !full;
  assign pop       = sel_data && f2hReady_in && !empty;
  assign ctrl_wr   = sel_ctrl && h2fValid_in;
  assign do_clear  = ctrl_wr && h2fData_in[0];
  assign do_flush  = ctrl_wr && h2fData_in[1];
  assign latch_lsb = sel_msb && f2hReady_in;

  assign status_byte = {full, empty, 6'(count_q)};
  assign head_byte   = empty ? 8'h00 : mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------------------------
  // Host-facing outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    selected_out = owned;
    h2fReady_out = 1'b1;
    f2hValid_out = 1'b0;
    f2hData_out  = 8'h00;
    if (owned) begin
      unique case (chan_off[1:0])
        2'd0: begin
          h2fReady_out = !full;
          f2hValid_out = !empty;
          f2hData_out  = head_byte;
        end
        2'd1: begin
          f2hValid_out = 1'b1;
          f2hData_out  = status_byte;
        end
        2'd2: begin
          f2hValid_out = 1'b1;
          f2hData_out  = cksum_q[15:8];
        end
        2'd3: begin
          f2hValid_out = 1'b1;
          f2hData_out  = shadow_q;
        end
      endcase
    end
  end

  assign checksum_out = cksum_q;
  assign count_out    = count_q;

  // ---------------------------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cksum_d  = cksum_q;
    shadow_d = shadow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
      cksum_d  = cksum_q + {8'h00, h2fData_in};
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (pop && !push) begin
      count_d = count_q - CntOne;
    end

    // Control writes only happen on the ctrl channel, so they never coincide with push/pop.
    if (do_clear) begin
      cksum_d = 16'h0000;
    end
    if (do_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // Capture the low byte on the same edge the high byte is consumed, so MSB-then-LSB reads form
    // one coherent 16-bit sample even if bytes are pushed in between.
    if (latch_lsb) begin
      shadow_d = cksum_q[7:0];
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge fx2Clk_in) begin
    if (reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cksum_q  <= 16'h0000;
      shadow_q <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cksum_q  <= cksum_d;
      shadow_q <= shadow_d;
    end
  end

  // Storage has no reset; contents are only observable through valid pointers.
  always_ff @(posedge fx2Clk_in) begin
    if (push && !reset_in) begin
      mem_q[wr_ptr_q] <= h2fData_in;
    end
  end

endmodule

// File: tb/tb_chan_cksum_fifo.sv
`timescale 1ns / 1ps

module tb_chan_cksum_fifo;

  localparam int unsigned DL   = 4;
  localparam int unsigned D    = 1 << DL;
  localparam logic [6:0]  BASE = 7'd0;
  localparam logic [6:0]  CH_DATA = BASE;
  localparam logic [6:0]  CH_CTRL = BASE + 7'd1;
  localparam logic [6:0]  CH_MSB  = BASE + 7'd2;
  localparam logic [6:0]  CH_LSB  = BASE + 7'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   chan;
  logic [7:0]   h2f_data;
  logic         h2f_valid;
  logic         h2f_ready;
  logic [7:0]   f2h_data;
  logic         f2h_valid;
  logic         f2h_ready;
  logic         selected;
  logic [15:0]  checksum;
  logic [DL:0]  count;

  always #5 clk = ~clk;

  chan_cksum_fifo #(
    .DEPTH_LOG2 (DL),
    .BASE_CHAN  (BASE)
  ) dut (
    .fx2Clk_in    (clk),
    .reset_in     (reset),
    .chanAddr_in  (chan),
    .h2fData_in   (h2f_data),
    .h2fValid_in  (h2f_valid),
    .h2fReady_out (h2f_ready),
    .f2hData_out  (f2h_data),
    .f2hValid_out (f2h_valid),
    .f2hReady_in  (f2h_ready),
    .selected_out (selected),
    .checksum_out (checksum),
    .count_out    (count)
  );

  // Expected observable outputs for one cycle.
  typedef struct {
    bit          en;
    bit          sel;
    bit          rdy;
    bit          vld;
    logic [7:0]  data;
    logic [15:0] cks;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: a byte queue, an arithmetic sum and a shadow byte.
  logic [7:0]  m_fifo[$];
  logic [15:0] m_sum    = 16'h0000;
  logic [7:0]  m_shadow = 8'h00;
  bit          m_known  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, want);
    end
  endtask

  // One clock cycle of stimulus: drive inputs, record what the outputs must be this cycle, then
  // advance the model as the coming edge will.
  task automatic cyc(input logic [6:0] ch, input logic [7:0] d, input bit hv, input bit fr,
                     input bit rst);
    exp_t e;
    int   off;
    int   sz;
    bit   do_pop;
    bit   do_push;
    @(posedge clk);
    #1;
    chan      = ch;
    h2f_data  = d;
    h2f_valid = hv;
    f2h_ready = fr;
    reset     = rst;

    off = (int'(ch) - int'(BASE) + 128) % 128;
    sz  = m_fifo.size();
    e.en   = m_known;
    e.sel  = (off < 4);
    e.rdy  = 1'b1;
    e.vld  = 1'b0;
    e.data = 8'h00;
    e.cks  = m_sum;
    e.cnt  = sz;
    case (off)
      0: begin
        e.rdy = (sz < D);
        e.vld = (sz > 0);
        if (sz > 0) e.data = m_fifo[0];
      end
      1: begin
        e.vld  = 1'b1;
        e.data = {sz == D, sz == 0, 6'(sz)};
      end
      2: begin
        e.vld  = 1'b1;
        e.data = m_sum[15:8];
      end
      3: begin
        e.vld  = 1'b1;
        e.data = m_shadow;
      end
      default: ;
    endcase
    exp_q.push_back(e);

    if (rst) begin
      m_fifo.delete();
      m_sum    = 16'h0000;
      m_shadow = 8'h00;
      m_known  = 1'b1;
    end else begin
      case (off)
        0: begin
          do_pop  = fr && (sz > 0);
          do_push = hv && (sz < D);
          if (do_pop) void'(m_fifo.pop_front());
          if (do_push) begin
            m_fifo.push_back(d);
            m_sum = m_sum + {8'h00, d};
          end
        end
        1: if (hv) begin
          if (d[0]) m_sum = 16'h0000;
          if (d[1]) m_fifo.delete();
        end
        2: if (fr) m_shadow = m_sum[7:0];
        default: ;
      endcase
    end
  endtask

  // Monitor: compares DUT outputs against the oldest expectation, mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.en) begin
          check("selected_out", 32'(selected), 32'(e.sel));
          check("h2fReady_out", 32'(h2f_ready), 32'(e.rdy));
          check("f2hValid_out", 32'(f2h_valid), 32'(e.vld));
          check("f2hData_out", 32'(f2h_data), 32'(e.data));
          check("checksum_out", 32'(checksum), 32'(e.cks));
          check("count_out", 32'(count), 32'(e.cnt));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int         r;
    int         guard;
    logic [7:0] d;
    logic [6:0] ch;
    bit         fill;
    reset     = 1'b1;
    chan      = 7'd0;
    h2f_data  = 8'h00;
    h2f_valid = 1'b0;
    f2h_ready = 1'b0;

    cyc(CH_DATA, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(CH_DATA, 8'h00, 1'b0, 1'b0, 1'b1);

    // Three writes, then status.
    cyc(CH_DATA, 8'h10, 1'b1, 1'b0, 1'b0);
    cyc(CH_DATA, 8'h20, 1'b1, 1'b0, 1'b0);
    cyc(CH_DATA, 8'h30, 1'b1, 1'b0, 1'b0);
    cyc(CH_CTRL, 8'h00, 1'b0, 1'b1, 1'b0);

    // Read back in order, then empty.
    repeat (4) cyc(CH_DATA, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(CH_CTRL, 8'h00, 1'b0, 1'b1, 1'b0);

    // Overfill by one, status, then push+pop while full (push refused).
    for (int i = 0; i < 17; i++) cyc(CH_DATA, 8'(i + 1), 1'b1, 1'b0, 1'b0);
    cyc(CH_CTRL, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(CH_DATA, 8'hAA, 1'b1, 1'b1, 1'b0);
    cyc(CH_DATA, 8'hAB, 1'b1, 1'b1, 1'b0);

    // Flush and clear together, then 257 bytes of 0xFF through a one-deep fill/drain.
    cyc(CH_CTRL, 8'hFF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 257; i++) cyc(CH_DATA, 8'hFF, 1'b1, 1'b1, 1'b0);
    cyc(CH_DATA, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(CH_MSB, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(CH_LSB, 8'h00, 1'b0, 1'b1, 1'b0);

    // Shadow coherence: LSB read after an intervening push returns the pre-push value.
    cyc(CH_MSB, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(CH_DATA, 8'h05, 1'b1, 1'b0, 1'b0);
    cyc(CH_LSB, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(CH_MSB, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(CH_LSB, 8'h00, 1'b0, 1'b1, 1'b0);
    // Writes to checksum channels are ignored; unowned channel causes no state change.
    cyc(CH_MSB, 8'h03, 1'b1, 1'b1, 1'b0);
    cyc(CH_LSB, 8'h03, 1'b1, 1'b1, 1'b0);
    cyc(7'd77, 8'h03, 1'b1, 1'b1, 1'b0);

    // Clear+flush with bytes queued, then reset mid-burst.
    for (int i = 0; i < 5; i++) cyc(CH_DATA, 8'(8'h41 + i), 1'b1, 1'b0, 1'b0);
    cyc(CH_CTRL, 8'h03, 1'b1, 1'b0, 1'b0);
    cyc(CH_CTRL, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(CH_DATA, 8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
    cyc(CH_DATA, 8'h77, 1'b1, 1'b1, 1'b1);
    cyc(CH_DATA, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(CH_CTRL, 8'h00, 1'b0, 1'b1, 1'b0);

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    fill = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) fill = ~fill;
      r = int'($urandom_range(0, 99));
      d = 8'($urandom);
      if (r == 0) begin
        cyc(CH_DATA, d, 1'b1, 1'b1, 1'b1);
      end else if (r < 55) begin
        cyc(CH_DATA, d, ($urandom_range(0, 3) < (fill ? 3 : 1)),
            ($urandom_range(0, 3) < (fill ? 1 : 3)), 1'b0);
      end else if (r < 70) begin
        if ($urandom_range(0, 7) != 0) d = d & 8'hFC;
        cyc(CH_CTRL, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end else if (r < 80) begin
        cyc(CH_MSB, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end else if (r < 90) begin
        cyc(CH_LSB, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        ch = 7'($urandom_range(4, 127)) + BASE;
        cyc(ch, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    // Let the monitor consume every outstanding expectation.
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
